// File: rtl/enemy_pkg.sv
// Shared types and constants for the two-lane enemy track controller.
package enemy_pkg;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_WALK,
        ST_DWELL,
        ST_HIT
    } slot_state_t;

    localparam logic [4:0] POS_ABSENT = 5'd31;

    // Taps for x^8+x^6+x^5+x^4+1: feedback taken from bits 7, 5, 4 and 3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/enemy_track_if.sv
// Game-side control and enemy-output bundle for enemy_track.
interface enemy_track_if;

    logic       en;
    logic       step;
    logic       atk_0;
    logic       atk_1;
    logic [4:0] pos_0;
    logic [4:0] pos_1;
    logic       hit_0;
    logic       hit_1;
    logic [7:0] kills;

    modport master (
        output en, step, atk_0, atk_1,
        input  pos_0, pos_1, hit_0, hit_1, kills
    );

    modport slave (
        input  en, step, atk_0, atk_1,
        output pos_0, pos_1, hit_0, hit_1, kills
    );

endinterface

// File: rtl/enemy_slot.sv
// One enemy slot: WAIT/WALK/DWELL/HIT sequencing, track position and
// hit-window detection for its lane.
module enemy_slot
    import enemy_pkg::*;
#(
    parameter logic [4:0] SPAWN_POS   = 5'd20,
    parameter logic [4:0] HIT_LO      = 5'd1,
    parameter logic [4:0] HIT_HI      = 5'd4,
    parameter logic [3:0] HIT_STEPS   = 4'd2,
    parameter logic [3:0] DWELL_STEPS = 4'd3,
    parameter logic [3:0] RESET_CNT   = 4'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       step,
    input  logic       atk,
    input  logic [2:0] delay_seed,
    output logic [4:0] pos,
    output logic       hit,
    output logic       landed
);

    slot_state_t state, state_nx;
    logic [4:0]  pos_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        hit_nx;
    logic [3:0]  wait_cnt;

    assign wait_cnt = 4'd1 + {1'b0, delay_seed};

    assign landed = en && atk && (state == ST_WALK) &&
                    (pos >= HIT_LO) && (pos <= HIT_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_WAIT;
            pos   <= POS_ABSENT;
            cnt   <= RESET_CNT;
            hit   <= 1'b0;
        end else begin
            state <= state_nx;
            pos   <= pos_nx;
            cnt   <= cnt_nx;
            hit   <= hit_nx;
        end
    end

    // A landed attack takes priority over a same-cycle step
    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        cnt_nx   = cnt;
        hit_nx   = hit;
        if (landed) begin
            state_nx = ST_HIT;
            hit_nx   = 1'b1;
            cnt_nx   = HIT_STEPS;
        end else if (en && step) begin
            case (state)
                ST_WAIT: begin
                    if (cnt > 4'd1) begin
                        cnt_nx = cnt - 4'd1;
                    end else begin
                        state_nx = ST_WALK;
                        pos_nx   = SPAWN_POS;
                    end
                end
                ST_WALK: begin
                    if (pos > 5'd1) begin
                        pos_nx = pos - 5'd1;
                    end else begin
                        state_nx = ST_DWELL;
                        pos_nx   = 5'd0;
                        cnt_nx   = DWELL_STEPS;
                    end
                end
                ST_DWELL, ST_HIT: begin
                    if (cnt > 4'd1) begin
                        cnt_nx = cnt - 4'd1;
                    end else begin
                        state_nx = ST_WAIT;
                        pos_nx   = POS_ABSENT;
                        cnt_nx   = wait_cnt;
                        hit_nx   = 1'b0;
                    end
                end
                default: begin
                    state_nx = ST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: rtl/enemy_track.sv
// Two-lane enemy behaviour controller: two slots, a free-running LFSR
// for respawn delays, and a saturating kill counter.
module enemy_track
    import enemy_pkg::*;
#(
    parameter logic [4:0] SPAWN_POS   = 5'd20,
    parameter logic [4:0] HIT_LO      = 5'd1,
    parameter logic [4:0] HIT_HI      = 5'd4,
    parameter logic [3:0] HIT_STEPS   = 4'd2,
    parameter logic [3:0] DWELL_STEPS = 4'd3,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic         clk,
    input  logic         rst,
    enemy_track_if.slave bus
);

    logic [7:0] lfsr;
    logic       landed_0;
    logic       landed_1;
    logic [8:0] kills_sum;

    enemy_slot #(
        .SPAWN_POS  (SPAWN_POS),
        .HIT_LO     (HIT_LO),
        .HIT_HI     (HIT_HI),
        .HIT_STEPS  (HIT_STEPS),
        .DWELL_STEPS(DWELL_STEPS),
        .RESET_CNT  (4'd1)
    ) u_slot_0 (
        .clk       (clk),
        .rst       (rst),
        .en        (bus.en),
        .step      (bus.step),
        .atk       (bus.atk_0),
        .delay_seed(lfsr[2:0]),
        .pos       (bus.pos_0),
        .hit       (bus.hit_0),
        .landed    (landed_0)
    );

    enemy_slot #(
        .SPAWN_POS  (SPAWN_POS),
        .HIT_LO     (HIT_LO),
        .HIT_HI     (HIT_HI),
        .HIT_STEPS  (HIT_STEPS),
        .DWELL_STEPS(DWELL_STEPS),
        .RESET_CNT  (4'd2)
    ) u_slot_1 (
        .clk       (clk),
        .rst       (rst),
        .en        (bus.en),
        .step      (bus.step),
        .atk       (bus.atk_1),
        .delay_seed(lfsr[5:3]),
        .pos       (bus.pos_1),
        .hit       (bus.hit_1),
        .landed    (landed_1)
    );

    // The LFSR keeps running while the game is paused
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign kills_sum = {1'b0, bus.kills} + 9'(landed_0) + 9'(landed_1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.kills <= 8'd0;
        end else begin
            bus.kills <= kills_sum[8] ? 8'hFF : kills_sum[7:0];
        end
    end

endmodule

// File: doc/enemy_track.md
# enemy_track

Upstream enemy behaviour controller for the two-lane enemy path. Spawns, walks, and retires two independent enemy slots on a game step tick, and resolves player attacks against a hit window. Produces the `pos_0`/`pos_1` track positions and `hit_0`/`hit_1` flags consumed by the enemy sprite/damage stage (`enemy0`), plus a saturating kill counter for the score display.

## Interface
Parameters:
- `SPAWN_POS`, 20: position loaded on spawn; must be ≤ 30.
- `HIT_LO`, 1: lowest position at which an attack lands.
- `HIT_HI`, 4: highest position at which an attack lands.
- `HIT_STEPS`, 2: steps an enemy stays in the hit state; must be ≥ 1.
- `DWELL_STEPS`, 3: steps an enemy parks at position 0; must be ≥ 1.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be non-zero.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  game running; when low, all slot state and `kills` freeze.
- `step`  in  1  one-cycle game tick pulse, synchronous to `clk`.
- `atk_0`, `atk_1`  in  1  one-cycle attack pulses for lane 0 and lane 1.
- `pos_0`, `pos_1`  out  5  track position. 5'd31 means absent/off-screen.
- `hit_0`, `hit_1`  out  1  enemy in the hit state.
- `kills`  out  8  saturating count of landed attacks.

## Operation
- Each slot has four states: WAIT, WALK, DWELL, HIT. Each slot has one 4-bit down-counter `cnt`.
- Reset values:
  - Both slots: state WAIT, `pos` = 31, `hit` = 0.
  - `cnt` = 1 for slot 0, 2 for slot 1.
  - `kills` = 0; LFSR = `LFSR_SEED`.
- WAIT (`pos` = 31):
  - On `step` with `cnt` > 1: `cnt` decrements.
  - On `step` with `cnt` = 1: go to WALK, `pos` = `SPAWN_POS`.
- WALK:
  - On `step` with `pos` > 1: `pos` decrements.
  - On `step` with `pos` = 1: `pos` = 0, go to DWELL, `cnt` = `DWELL_STEPS`.
- An attack lands when the lane's `atk` is high, the slot is in WALK, and `HIT_LO` ≤ `pos` ≤ `HIT_HI`. The comparison uses the pre-step `pos`. On a landed attack:
  - Go to HIT: `hit` = 1, `pos` held, `cnt` = `HIT_STEPS`.
  - `kills` increments.
  - A `step` in the same cycle is ignored for that slot.
- Attacks in any other state or position are ignored.
- DWELL (`pos` = 0): on `step`, `cnt` decrements. At `cnt` = 1, go to WAIT.
- HIT: on `step`, `cnt` decrements. At `cnt` = 1, go to WAIT with `hit` = 0.
- On entry to WAIT:
  - `pos` = 31.
  - Slot 0 loads `cnt` = 1 + `lfsr[2:0]`; slot 1 loads `cnt` = 1 + `lfsr[5:3]`. Range is 1..8 steps.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts left each `clk` cycle; feedback = b7^b5^b4^b3 into b0.
  - Free-runs regardless of `en`.
- `kills`:
  - Adds 0, 1 or 2 (both lanes may land in the same cycle).
  - Saturates at 255; 254 + 2 = 255.
- When `en` = 0, `step` and `atk` are ignored.

## Timing
- All outputs are registered. A change appears on the `clk` edge that samples the causing `step`/`atk`, i.e. visible the following cycle.
- `rst` clears all outputs immediately, independent of `clk`, including mid-HIT or mid-WALK.
- `step` and `atk` are single-cycle level samples. A multi-cycle pulse counts once per cycle high.
- Each slot acts on at most one transition per cycle.

## Structure
- Package `enemy_pkg` holds:
  - the slot state enum (WAIT/WALK/DWELL/HIT);
  - `POS_ABSENT` = 5'd31;
  - the LFSR tap constant.
- Sub-module `enemy_slot` holds one slot's FSM, `pos`, `cnt` and hit-window compare. It has inputs `step`, `atk`, `en`, `delay_seed[2:0]` and outputs `pos`, `hit`, `landed`. The top instantiates it twice and owns the LFSR and the `kills` adder.

## Test plan
- Reset, then `en` = 1 and `step` every 4 cycles:
  - 1st step → `pos_0` = 20.
  - 2nd step → `pos_1` = 20, `pos_0` = 19.
  - 20 steps after spawn → `pos_0` = 0.
  - 3 more steps → `pos_0` = 31.
- `pos_0` = 3, pulse `atk_0` → next cycle `hit_0` = 1, `kills` = 1, `pos_0` = 3. After 2 steps → `hit_0` = 0, `pos_0` = 31.
- `atk_0` at `pos_0` = 5, and `atk_0` during DWELL (`pos_0` = 0) → `hit_0` stays 0, `kills` unchanged.
- `step` and `atk_1` in the same cycle with `pos_1` = 4 → `hit_1` = 1, `pos_1` = 4 (no decrement).
- `kills` preloaded to 254 via landed attacks; both lanes land in one cycle → `kills` = 255. A further hit → 255.
- Assert `rst` between clock edges while `hit_0` = 1 → `hit_0` = 0, `pos_0` = 31, `kills` = 0 before the next edge. `en` = 0 for 10 steps → all outputs constant.
